// File: rtl/led_matrix_scanner.sv
// Multiplexed 8x8 LED matrix row scanner.
// Each row goes through BLANK (all LEDs dark), LOAD (capture the row's column
// pattern), then SHOW (one row lit with the captured pattern). After row 7 the
// scan wraps to row 0 and quadro_fim pulses once per frame.
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - synchronous active-low reset
//   enable       - 1 = scan, 0 = park in IDLE with matrix dark
//   coluna_dado  - column pattern for row `indice` (registered by the source)
//   indice       - row index presented to the pattern source
//   linha_sel    - one-hot active-high row drive
//   coluna_out   - active-high column drive for the lit row
//   quadro_fim   - one-cycle pulse on the first BLANK cycle after row 7
module led_matrix_scanner #(
    parameter int unsigned TICKS_LINHA  = 1000,
    parameter int unsigned BLANK_CICLOS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] coluna_dado,
    output logic [2:0] indice,
    output logic [7:0] linha_sel,
    output logic [7:0] coluna_out,
    output logic       quadro_fim
);

    localparam int unsigned TICK_W  = 16;
    localparam int unsigned BLANK_W = 8;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned COL_W   = 8;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_LINHA - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CICLOS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        LOAD  = 2'd2,
        SHOW  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   indice_q, indice_d;
    logic [COL_W-1:0]   linha_q, linha_d;
    logic [COL_W-1:0]   coluna_q, coluna_d;
    logic               fim_q, fim_d;

    // Next-state logic; outputs are computed for the state being entered so
    // that the registered outputs always match the registered state.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        blank_d  = blank_q;
        col_d    = col_q;
        indice_d = indice_q;
        linha_d  = '0;
        coluna_d = '0;
        fim_d    = 1'b0;

        if (!enable) begin
            // Dropping enable abandons the current row; scan restarts at row 0.
            state_d  = IDLE;
            tick_d   = '0;
            blank_d  = '0;
            indice_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    blank_d  = '0;
                    indice_d = '0;
                end
                BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        state_d = LOAD;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + BLANK_W'(1);
                    end
                end
                LOAD: begin
                    // Source pattern is stable here: indice changed at least one
                    // BLANK cycle ago.
                    state_d  = SHOW;
                    tick_d   = '0;
                    col_d    = coluna_dado;
                    linha_d  = COL_W'(1) << indice_q;
                    coluna_d = coluna_dado;
                end
                SHOW: begin
                    if (tick_q == TICK_LAST) begin
                        state_d  = BLANK;
                        tick_d   = '0;
                        indice_d = indice_q + ROW_W'(1);
                        fim_d    = (indice_q == ROW_W'(7));
                    end else begin
                        tick_d   = tick_q + TICK_W'(1);
                        linha_d  = COL_W'(1) << indice_q;
                        coluna_d = col_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            blank_q  <= '0;
            col_q    <= '0;
            indice_q <= '0;
            linha_q  <= '0;
            coluna_q <= '0;
            fim_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            blank_q  <= blank_d;
            col_q    <= col_d;
            indice_q <= indice_d;
            linha_q  <= linha_d;
            coluna_q <= coluna_d;
            fim_q    <= fim_d;
        end
    end

    assign indice     = indice_q;
    assign linha_sel  = linha_q;
    assign coluna_out = coluna_q;
    assign quadro_fim = fim_q;

endmodule
